rr_data_arbiter: RTL and testbench
==================================

# rr_data_arbiter

Round-robin arbiter sharing one registered 4-bit output channel among up to eight requesters. It is the sequencing front end for the select-driven data mux in the motion-update datapath. It replaces the static select field with a fair, handshaked choice of source and registers the winning word with its source index. Downstream stages then consume data through a valid/ready interface instead of a free-running select.

## Interface
- NUM_REQ, 8, number of requesters; legal range 2..8.
- DATA_W, 4, width of each data word.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- req_valid  in  NUM_REQ  per-requester valid; bit i belongs to requester i.
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot-or-zero accept strobe; bit i high means word i is taken this cycle.
- out_valid  out  1  output register holds a word.
- out_data  out  DATA_W  registered winning word.
- out_src  out  3  index of the requester that supplied out_data.
- out_ready  in  1  downstream accept.
- grant_cnt  out  16  accepted-transfer count; present only with ARB_GRANT_CNT_EN.
- cnt_clr  in  1  synchronous clear of grant_cnt; present only with ARB_GRANT_CNT_EN.

## Operation
- Two-state FSM on the output register:
  - EMPTY: out_valid = 0.
  - FULL: out_valid = 1.
- Load enable: ld = (state == EMPTY) | (out_valid & out_ready).
- Arbitration:
  - Search req_valid starting at index ptr, ascending, wrapping modulo NUM_REQ.
  - The first set bit wins.
  - req_ready[win] = ld & |req_valid; all other req_ready bits are 0.
  - req_ready is combinational from req_valid, ptr, state and out_ready.
- Accept (ld and at least one req_valid):
  - out_data <= winning word; out_src <= win; state -> FULL.
  - ptr <= (win + 1) mod NUM_REQ.
- No accept while ld = 1:
  - If the register drained this cycle, state -> EMPTY.
  - ptr and out_data hold.
- FULL with out_ready = 0: all outputs hold; req_ready = 0.
- Requester rules:
  - Hold req_valid and the data word stable until req_ready is sampled high.
  - Deasserting req_valid before it is granted is allowed; that request is simply dropped from arbitration.
- Fairness: a requester that stays valid is granted within NUM_REQ accepts.
- Bits of req_valid at index >= NUM_REQ do not exist; ptr never exceeds NUM_REQ-1.

## Timing
- Reset (asynchronous assert, released synchronously by the clock domain):
  - out_valid = 0, out_data = 0, out_src = 0, ptr = 0, state = EMPTY, grant_cnt = 0.
  - req_ready = 0 while rst_n = 0.
- Latency: 1 cycle from the req_ready edge to out_valid/out_data visible.
- Throughput: 1 word per cycle while out_ready is held high.
- Simultaneous drain and load in FULL: the new word replaces the old one in the same edge, and out_valid stays 1.
- Reset mid-transfer: the word in the register is discarded; no req_ready is issued in the reset cycle.
- ptr wrap: a win at NUM_REQ-1 sets ptr to 0.

## Configuration
- ARB_GRANT_CNT_EN defined:
  - grant_cnt and cnt_clr ports exist.
  - grant_cnt increments once per accept and saturates at 0xFFFF.
  - cnt_clr has priority over increment: the counter becomes 0 on that edge and the same-cycle accept is not counted.
- ARB_GRANT_CNT_EN undefined: the ports and counter logic are absent; all other behaviour is identical.

## Test plan
- Reset, then req_valid = 0x00 for 5 cycles -> out_valid = 0, out_data = 0, out_src = 0, req_ready = 0 throughout.
- req_valid = 0xFF with out_ready = 1 held, word i = i+1 -> out_src sequence 0,1,...,7,0, out_data 1..8,1, with one word per cycle after the first cycle of latency.
- Only requester 5 valid with out_ready = 1 -> it is granted every cycle, ptr cycles 6→6, and out_src = 5 each cycle.
- req_valid = 0x81 with out_ready low after the first accept -> req_ready = 0 and out_data frozen; on out_ready rising, the next grant goes to requester 7, then 0.
- Assert rst_n = 0 mid-stream while FULL -> out_valid drops immediately without waiting for a clock edge; after release the first grant goes to requester 0.
- With ARB_GRANT_CNT_EN: 70000 accepts -> grant_cnt = 0xFFFF; then cnt_clr pulsed together with an accept -> grant_cnt = 0, and the next accept gives 1.

Source files
------------

// File: rtl/rr_data_arbiter.sv
// rr_data_arbiter
//
// Round-robin arbiter that shares one registered output word among up to eight
// requesters. The winning word is captured together with its source index, and
// the registered result is handed downstream through a valid/ready handshake.
//
// Optional feature macro: ARB_GRANT_CNT_EN
//   When this macro is defined, the module adds a 16-bit saturating count of
//   accepted transfers (grant_cnt_o) and a synchronous clear input (cnt_clr_i).
//
// Parameters
//   NUM_REQ      number of requesters, legal range 2..8
//   DATA_W       width of each data word
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   req_valid_i  per-requester valid; bit i belongs to requester i
//   req_data_i   packed words; requester i is at [i*DATA_W +: DATA_W]
//   req_ready_o  one-hot-or-zero accept strobe (combinational)
//   out_valid_o  output register holds a word
//   out_data_o   registered winning word
//   out_src_o    index of the requester that supplied out_data_o
//   out_ready_i  downstream accept
//   grant_cnt_o  accepted-transfer count (ARB_GRANT_CNT_EN only)
//   cnt_clr_i    synchronous clear of grant_cnt_o (ARB_GRANT_CNT_EN only)

module rr_data_arbiter #(
  parameter int unsigned NUM_REQ = 8,
  parameter int unsigned DATA_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      out_valid_o,
  output logic [DATA_W-1:0]         out_data_o,
  output logic [2:0]                out_src_o,
  input  logic                      out_ready_i
`ifdef ARB_GRANT_CNT_EN
  ,
  output logic [15:0]               grant_cnt_o,
  input  logic                      cnt_clr_i
`endif
);

  // The pointer and the source index share one 3-bit encoding, which covers
  // every legal NUM_REQ.
  localparam int unsigned PtrW = 3;

  localparam logic [0:0] StEmpty = 1'b0;
  localparam logic [0:0] StFull  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [PtrW-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [PtrW-1:0]   src_q, src_d;

  logic              ld;
  logic              any_valid;
  logic              accept;
  logic [PtrW-1:0]   win;
  logic [PtrW-1:0]   ptr_inc;
  logic [DATA_W-1:0] win_data;
  logic [7:0]        valid_pad;
  logic [7:0]        grant_oh;

  // The register can take a new word when it is empty, or when it is being
  // drained in this same cycle.
  assign ld        = (state_q == StEmpty) | (out_valid_o & out_ready_i);
  assign any_valid = |req_valid_i;
  assign accept    = ld & any_valid;

  // Pad req_valid_i to eight bits so that the wrapped search can always index
  // with the 3-bit pointer encoding. Bits at or above NUM_REQ read as zero.
  always_comb begin
    valid_pad = '0;
    valid_pad[NUM_REQ-1:0] = req_valid_i;
  end

  // Search req_valid_i upward from ptr_q, wrapping modulo NUM_REQ. The first
  // set bit found is the winner. If no bit is set, win keeps the value of
  // ptr_q; in that case accept is low, so the value is never used.
  always_comb begin
    logic [31:0]     idx;
    logic [PtrW-1:0] idx_w;
    logic            found;
    win   = ptr_q;
    found = 1'b0;
    idx   = '0;
    idx_w = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = {29'd0, ptr_q} + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      idx_w = idx[PtrW-1:0];
      if (!found && valid_pad[idx_w]) begin
        found = 1'b1;
        win   = idx_w;
      end
    end
  end

  // Select the winning word. This is written as an explicit mux so that the
  // part-select base is always a constant.
  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (win == PtrW'(i)) begin
        win_data = req_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Advance the pointer past the winner, wrapping from NUM_REQ-1 back to 0.
  assign ptr_inc = (win == PtrW'(NUM_REQ - 1)) ? '0 : win + 1'b1;

  // Gate the accept strobe with rst_n, so that no requester sees a grant
  // while reset is asserted. The state register reads EMPTY during reset, so
  // without this gate ld would be high.
  always_comb begin
    grant_oh = '0;
    if (accept && rst_n) begin
      grant_oh[win] = 1'b1;
    end
  end

  assign req_ready_o = grant_oh[NUM_REQ-1:0];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    src_d   = src_q;
    if (accept) begin
      state_d = StFull;
      data_d  = win_data;
      src_d   = win;
      ptr_d   = ptr_inc;
    end else if (ld) begin
      // The word drained (or the register was already empty) and nothing
      // replaced it. The old data stays in the register but is no longer
      // valid.
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      ptr_q   <= '0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  assign out_valid_o = (state_q == StFull);
  assign out_data_o  = data_q;
  assign out_src_o   = src_q;

`ifdef ARB_GRANT_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  // A clear takes priority over an accept in the same cycle; that accept is
  // not counted.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (accept && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_rr_data_arbiter.sv
module tb_rr_data_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req_valid;
  logic [31:0] req_data;
  logic [7:0]  req_ready;
  logic        out_valid;
  logic [3:0]  out_data;
  logic [2:0]  out_src;
  logic        out_ready;
`ifdef ARB_GRANT_CNT_EN
  logic [15:0] grant_cnt;
  logic        cnt_clr;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rr_data_arbiter #(
    .NUM_REQ(8),
    .DATA_W (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid_i(req_valid),
    .req_data_i (req_data),
    .req_ready_o(req_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_src_o  (out_src),
    .out_ready_i(out_ready)
`ifdef ARB_GRANT_CNT_EN
    ,
    .grant_cnt_o(grant_cnt),
    .cnt_clr_i  (cnt_clr)
`endif
  );

  // Drive reset for two clocks and release it on a falling edge.
  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 8'h00;
    out_ready = 1'b0;
`ifdef ARB_GRANT_CNT_EN
    cnt_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 8'hFF;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 8'h00) begin
      failures++;
      $display("FAIL reset_ready: got %h want 00", req_ready);
    end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 3'd0) begin
      failures++;
      $display("FAIL reset_outputs: got v=%b d=%h s=%0d want v=0 d=0 s=0",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 8'h00;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++;
      if (req_ready !== 8'h00) begin
        failures++;
        $display("FAIL idle_ready[%0d]: got %h want 00", c, req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 3'd0) begin
        failures++;
        $display("FAIL idle_outputs[%0d]: got v=%b d=%h s=%0d want v=0 d=0 s=0",
                 c, out_valid, out_data, out_src);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [2:0] s;
    logic [7:0] exp_ready;
    apply_reset();
    req_valid = 8'hFF;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      s = 3'(k % 8);
      exp_ready = 8'h01 << s;
      #1;
      checks++;
      if (req_ready !== exp_ready) begin
        failures++;
        $display("FAIL rr_ready[%0d]: got %h want %h", k, req_ready, exp_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== s || out_data !== 4'(s + 3'd1)) begin
        failures++;
        $display("FAIL rr_out[%0d]: got v=%b s=%0d d=%h want v=1 s=%0d d=%h",
                 k, out_valid, out_src, out_data, s, 4'(s + 3'd1));
      end
      @(negedge clk);
    end
  endtask

  // Continues from test_round_robin; only requester 5 is valid.
  task automatic test_single();
    req_valid = 8'h20;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (req_ready !== 8'h20) begin
        failures++;
        $display("FAIL single_ready[%0d]: got %h want 20", k, req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== 3'd5 || out_data !== 4'h6) begin
        failures++;
        $display("FAIL single_out[%0d]: got v=%b s=%0d d=%h want v=1 s=5 d=6",
                 k, out_valid, out_src, out_data);
      end
      @(negedge clk);
    end
  endtask

  // Drain with no new requests: the register empties and the data holds.
  task automatic test_drain();
    req_valid = 8'h00;
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 8'h00) begin
      failures++;
      $display("FAIL drain_ready: got %h want 00", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h6 || out_src !== 3'd5) begin
      failures++;
      $display("FAIL drain_out: got v=%b d=%h s=%0d want v=0 d=6 s=5",
               out_valid, out_data, out_src);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    apply_reset();
    req_valid = 8'h81;
    out_ready = 1'b0;
    #1;
    checks++;
    if (req_ready !== 8'h01) begin
      failures++;
      $display("FAIL stall_first_ready: got %h want 01", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 4'h1) begin
      failures++;
      $display("FAIL stall_first_out: got v=%b s=%0d d=%h want v=1 s=0 d=1",
               out_valid, out_src, out_data);
    end
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (req_ready !== 8'h00) begin
        failures++;
        $display("FAIL stall_ready[%0d]: got %h want 00", c, req_ready);
      end
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 4'h1) begin
        failures++;
        $display("FAIL stall_hold[%0d]: got v=%b s=%0d d=%h want v=1 s=0 d=1",
                 c, out_valid, out_src, out_data);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (req_ready !== 8'h80) begin
      failures++;
      $display("FAIL resume_ready7: got %h want 80", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd7 || out_data !== 4'h8) begin
      failures++;
      $display("FAIL resume_out7: got v=%b s=%0d d=%h want v=1 s=7 d=8",
               out_valid, out_src, out_data);
    end
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 8'h01) begin
      failures++;
      $display("FAIL resume_ready0: got %h want 01", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 4'h1) begin
      failures++;
      $display("FAIL resume_out0: got v=%b s=%0d d=%h want v=1 s=0 d=1",
               out_valid, out_src, out_data);
    end
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    apply_reset();
    req_valid = 8'hFF;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 4'h0 || out_src !== 3'd0 ||
        req_ready !== 8'h00) begin
      failures++;
      $display("FAIL async_reset: got v=%b d=%h s=%0d r=%h want v=0 d=0 s=0 r=00",
               out_valid, out_data, out_src, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 8'h01) begin
      failures++;
      $display("FAIL post_reset_ready: got %h want 01", req_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_src !== 3'd0 || out_data !== 4'h1) begin
      failures++;
      $display("FAIL post_reset_out: got v=%b s=%0d d=%h want v=1 s=0 d=1",
               out_valid, out_src, out_data);
    end
    @(negedge clk);
  endtask

`ifdef ARB_GRANT_CNT_EN
  task automatic test_grant_cnt();
    apply_reset();
    #1;
    checks++;
    if (grant_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL cnt_reset: got %h want 0000", grant_cnt);
    end
    req_valid = 8'hFF;
    out_ready = 1'b1;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    checks++;
    if (grant_cnt !== 16'hFFFF) begin
      failures++;
      $display("FAIL cnt_saturate: got %h want ffff", grant_cnt);
    end
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (grant_cnt !== 16'h0000) begin
      failures++;
      $display("FAIL cnt_clear: got %h want 0000", grant_cnt);
    end
    @(negedge clk);
    cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (grant_cnt !== 16'h0001) begin
      failures++;
      $display("FAIL cnt_after_clear: got %h want 0001", grant_cnt);
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    rst_n     = 1'b1;
    req_valid = 8'h00;
    out_ready = 1'b0;
`ifdef ARB_GRANT_CNT_EN
    cnt_clr   = 1'b0;
`endif
    for (int i = 0; i < 8; i++) begin
      req_data[i*4 +: 4] = 4'(i + 1);
    end
    test_reset();
    test_round_robin();
    test_single();
    test_drain();
    test_stall();
    test_async_reset();
`ifdef ARB_GRANT_CNT_EN
    test_grant_cnt();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
